// File: rtl/larpix_rx_pkg.sv
// Shared definitions for the LArPix receive path: packet-declare codes,
// header field positions, the broadcast chip ID and the unload FSM states.
package larpix_rx_pkg;

  // Packet-declare codes carried in bits [1:0] of every packet
  typedef enum logic [1:0] {
    DATA         = 2'd0,
    TEST         = 2'd1,
    CONFIG_WRITE = 2'd2,
    CONFIG_READ  = 2'd3
  } pkt_declare_e;

  // Header field positions inside the 63-bit packet
  localparam int PKT_TYPE_LSB = 0;
  localparam int PKT_TYPE_MSB = 1;
  localparam int CHIP_ID_LSB  = 2;
  localparam int CHIP_ID_MSB  = 9;

  // Broadcast chip ID, never removed by the filter
  localparam logic [7:0] GLOBAL_ID = 8'hFF;

  // Unload handshake states towards the UART receiver
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ULD  = 2'd1,
    CAPT = 2'd2,
    REL  = 2'd3
  } rx_state_e;

  // True when a packet from chip 'id' has to be discarded by the filter
  function automatic logic chip_rejected(input logic en, input logic [7:0] id,
                                         input logic [7:0] accepted);
    return en && (id != accepted) && (id != GLOBAL_ID);
  endfunction

endpackage

// File: rtl/rx_packet_collector_if.sv
// Packet output stream of the collector: FWFT head plus valid/ready handshake.
interface rx_packet_collector_if #(
  parameter int WIDTH = 64
);
  logic             pkt_valid;
  logic             pkt_ready;
  logic [WIDTH-2:0] pkt_data;
  logic             pkt_parity_err;
  logic [1:0]       pkt_type;
  logic [7:0]       pkt_chip_id;

  // Producer side (the collector)
  modport master (
    output pkt_valid, pkt_data, pkt_parity_err, pkt_type, pkt_chip_id,
    input  pkt_ready
  );

  // Consumer side
  modport slave (
    input  pkt_valid, pkt_data, pkt_parity_err, pkt_type, pkt_chip_id,
    output pkt_ready
  );
endinterface

// File: rtl/rx_packet_fifo.sv
// First-word-fall-through packet buffer. Head entry is visible combinationally;
// a push into a full buffer is accepted only when a pop happens in the same cycle.
module rx_packet_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == FULL_CNT);
  assign do_pop  = pop_i && valid_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign count_o = count_q;
  // Gate the head so the outputs never show uninitialised storage
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  // Storage write; contents need no reset because reads are gated by valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rx_packet_collector.sv
// Unloads words from the UART receiver, filters them by chip ID, buffers them
// in an FWFT FIFO and keeps saturating statistics counters.
module rx_packet_collector
  import larpix_rx_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  // UART receiver side
  input  logic                          rx_empty,
  input  logic [WIDTH-2:0]              rx_data,
  input  logic                          parity_error,
  output logic                          uld_rx_data,
  // Filter and statistics control
  input  logic                          filter_en,
  input  logic [7:0]                    chip_id_filter,
  input  logic                          clr_cnt,
  // Packet stream
  rx_packet_collector_if.master         pkt_if,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_WIDTH-1:0]          rx_cnt,
  output logic [CNT_WIDTH-1:0]          parity_err_cnt,
  output logic [CNT_WIDTH-1:0]          filtered_cnt,
  output logic [CNT_WIDTH-1:0]          drop_cnt
);
  rx_state_e        state_q;
  logic             uld_q;
  logic [WIDTH-1:0] cap_q;    // {parity flag, packet}
  logic             eval_q;   // high during the REL entry cycle only

  logic             filter_hit;
  logic             push;
  logic             pop;
  logic             fifo_valid;
  logic             fifo_full;
  logic [WIDTH-1:0] head;
  logic [3:0]       inc;

  // Unload handshake: strobe for ULD+CAPT, capture on leaving CAPT,
  // hold in REL until the receiver reports empty
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      uld_q   <= 1'b0;
      cap_q   <= '0;
      eval_q  <= 1'b0;
    end else begin
      eval_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_empty) begin
            state_q <= ULD;
            uld_q   <= 1'b1;
          end
        end
        ULD: begin
          state_q <= CAPT;
          uld_q   <= 1'b1;
        end
        CAPT: begin
          state_q <= REL;
          uld_q   <= 1'b0;
          cap_q   <= {parity_error, rx_data};
          eval_q  <= 1'b1;
        end
        REL: begin
          if (rx_empty) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          uld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign uld_rx_data = uld_q;

  // Evaluation of the captured word in the REL entry cycle
  assign filter_hit = chip_rejected(filter_en, cap_q[CHIP_ID_MSB:CHIP_ID_LSB], chip_id_filter);
  assign push       = eval_q && !filter_hit;
  assign pop        = fifo_valid && pkt_if.pkt_ready;

  rx_packet_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (push),
    .data_i  (cap_q),
    .pop_i   (pop),
    .head_o  (head),
    .valid_o (fifo_valid),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign pkt_if.pkt_valid      = fifo_valid;
  assign pkt_if.pkt_data       = head[WIDTH-2:0];
  assign pkt_if.pkt_parity_err = head[WIDTH-1];
  assign pkt_if.pkt_type       = head[PKT_TYPE_MSB:PKT_TYPE_LSB];
  assign pkt_if.pkt_chip_id    = head[CHIP_ID_MSB:CHIP_ID_LSB];

  // Counter events: 0 received, 1 parity error, 2 filtered, 3 dropped on full
  assign inc[0] = eval_q;
  assign inc[1] = eval_q && cap_q[WIDTH-1];
  assign inc[2] = eval_q && filter_hit;
  assign inc[3] = push && fifo_full && !pop;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_q;
      // Saturating statistics counter; clear has priority over increment
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q <= '0;
        end else if (clr_cnt) begin
          cnt_q <= '0;
        end else if (inc[gi] && (cnt_q != '1)) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  endgenerate

  assign rx_cnt         = g_cnt[0].cnt_q;
  assign parity_err_cnt = g_cnt[1].cnt_q;
  assign filtered_cnt   = g_cnt[2].cnt_q;
  assign drop_cnt       = g_cnt[3].cnt_q;

endmodule
